fht_stage_seq: RTL and testbench

Stage sequencer for the radix-2 FHT datapath. It sits directly upstream of `fht_but`. For every stage and butterfly it generates the three data-RAM read addresses (x0, x1, x2) and the twiddle-ROM address (sin/cos). It also generates the delayed write-back addresses and enables for the butterfly outputs y0/y1. Data RAM is ping-pong across two banks, so no in-place hazards exist. Bit-reversed input ordering is the loader's responsibility.

---
 rtl/fht_stage_seq.sv | 163 ++++++++++++++++
 tb/tb_fht_stage_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fht_stage_seq.sv
// Radix-2 FHT stage sequencer: issues x0/x1/x2 read addresses and the twiddle
// index for one butterfly per cycle, and replays the y0/y1 destinations
// D = RAM_LAT + BUT_LAT cycles later through a write-back shift register.
module fht_stage_seq #(
  parameter int N_LOG2  = 10,
  parameter int RAM_LAT = 1,
  parameter int BUT_LAT = 1
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iSTART,
  output logic                      oBUSY,
  output logic                      oDONE,
  output logic [$clog2(N_LOG2)-1:0] oSTAGE,
  output logic                      oRD_EN,
  output logic                      oRD_BANK,
  output logic [N_LOG2-1:0]         oRD_ADDR_0,
  output logic [N_LOG2-1:0]         oRD_ADDR_1,
  output logic [N_LOG2-1:0]         oRD_ADDR_2,
  output logic [N_LOG2-2:0]         oROM_ADDR,
  output logic                      oWR_EN,
  output logic                      oWR_BANK,
  output logic [N_LOG2-1:0]         oWR_ADDR_0,
  output logic [N_LOG2-1:0]         oWR_ADDR_1
);

  localparam int D  = RAM_LAT + BUT_LAT;
  localparam int AW = N_LOG2;
  localparam int JW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam int DW = $clog2(D + 1);

  typedef logic [AW-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // One read-side butterfly record; entry 0 is the live read, entry D the write-back.
  typedef struct packed {
    addr_t a;
    addr_t b;
    logic  sb;   // stage bit of the read (also the read bank)
  } wb_t;

  state_t          state, nxt_state;
  logic [SW-1:0]   s, nxt_s;
  logic [JW-1:0]   j, nxt_j;
  logic [DW-1:0]   dcnt, nxt_dcnt;
  logic            done_n, rd_n;

  logic [D:0]      vld_pipe;
  wb_t             wb_pipe [0:D];
  addr_t           c_q;
  logic [JW-1:0]   rom_q;

  addr_t           half, jx, k, base, a_n, b_n, c_n;
  logic [JW-1:0]   rom_n;

  // Next-state logic: RUN walks j over N/2 butterflies, DRAIN waits D cycles
  // so the last writes of a stage land before the next stage reads that bank.
  always_comb begin
    nxt_state = state;
    nxt_s     = s;
    nxt_j     = j;
    nxt_dcnt  = dcnt;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        // oDONE still high means the transform just ended; hold off one cycle.
        if (iSTART && !oDONE) begin
          nxt_state = RUN;
          nxt_s     = '0;
          nxt_j     = '0;
        end
      end
      RUN: begin
        if (j == {JW{1'b1}}) begin
          nxt_state = DRAIN;
          nxt_dcnt  = '0;
        end else begin
          nxt_j = j + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DW'(D - 1)) begin
          nxt_j = '0;
          if (s == SW'(N_LOG2 - 1)) begin
            nxt_state = IDLE;
            nxt_s     = '0;
            done_n    = 1'b1;
          end else begin
            nxt_state = RUN;
            nxt_s     = s + 1'b1;
          end
        end else begin
          nxt_dcnt = dcnt + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign rd_n = (nxt_state == RUN);

  // Butterfly addresses for the next cycle's (s, j), so outputs come straight from flops.
  always_comb begin
    half  = addr_t'(1) << nxt_s;
    jx    = addr_t'(nxt_j);
    k     = jx & (half - addr_t'(1));
    base  = ((jx >> nxt_s) << nxt_s) << 1;
    a_n   = base + k;
    b_n   = base + half + k;
    // Mirror partner of k within the group; wraps onto b at k = 0.
    c_n   = base + half + ((half - k) & (half - addr_t'(1)));
    rom_n = k[JW-1:0] << (JW - nxt_s);
  end

  // Control state register and status outputs.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
      dcnt  <= '0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      state <= nxt_state;
      s     <= nxt_s;
      j     <= nxt_j;
      dcnt  <= nxt_dcnt;
      oBUSY <= (nxt_state != IDLE);
      oDONE <= done_n;
    end
  end

  // Read registers plus the write-back delay line; idle slots carry zeros.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      vld_pipe <= '0;
      c_q      <= '0;
      rom_q    <= '0;
      for (int i = 0; i <= D; i++) wb_pipe[i] <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[D-1:0], rd_n};
      c_q        <= rd_n ? c_n   : '0;
      rom_q      <= rd_n ? rom_n : '0;
      wb_pipe[0] <= rd_n ? wb_t'{a: a_n, b: b_n, sb: nxt_s[0]} : '0;
      for (int i = 1; i <= D; i++) wb_pipe[i] <= wb_pipe[i-1];
    end
  end

  assign oSTAGE     = s;
  assign oRD_EN     = vld_pipe[0];
  assign oRD_BANK   = wb_pipe[0].sb;
  assign oRD_ADDR_0 = wb_pipe[0].a;
  assign oRD_ADDR_1 = wb_pipe[0].b;
  assign oRD_ADDR_2 = c_q;
  assign oROM_ADDR  = rom_q;
  assign oWR_EN     = vld_pipe[D];
  assign oWR_BANK   = vld_pipe[D] & ~wb_pipe[D].sb;
  assign oWR_ADDR_0 = wb_pipe[D].a;
  assign oWR_ADDR_1 = wb_pipe[D].b;

endmodule

// File: tb/tb_fht_stage_seq.sv
// Directed bench for fht_stage_seq: full N=8 transform address trace, ignored
// starts, start/oDONE overlap, mid-run reset, and an N=16 / D=4 latency sweep.
module tb_fht_stage_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  // N_LOG2=3, D=2
  logic       busy, done, rd_en, rd_bank, wr_en, wr_bank;
  logic [1:0] stage, rom;
  logic [2:0] ra0, ra1, ra2, wa0, wa1;

  // N_LOG2=4, D=4
  logic       b2, d2, re2, rb2, we2, wb2;
  logic [1:0] st2;
  logic [2:0] rom2;
  logic [3:0] r20, r21, r22, w20, w21;

  fht_stage_seq #(.N_LOG2(3), .RAM_LAT(1), .BUT_LAT(1)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oBUSY(busy), .oDONE(done), .oSTAGE(stage),
    .oRD_EN(rd_en), .oRD_BANK(rd_bank),
    .oRD_ADDR_0(ra0), .oRD_ADDR_1(ra1), .oRD_ADDR_2(ra2), .oROM_ADDR(rom),
    .oWR_EN(wr_en), .oWR_BANK(wr_bank), .oWR_ADDR_0(wa0), .oWR_ADDR_1(wa1));

  fht_stage_seq #(.N_LOG2(4), .RAM_LAT(1), .BUT_LAT(3)) dut2 (
    .iCLK(clk), .iRESET(rst), .iSTART(start2),
    .oBUSY(b2), .oDONE(d2), .oSTAGE(st2),
    .oRD_EN(re2), .oRD_BANK(rb2),
    .oRD_ADDR_0(r20), .oRD_ADDR_1(r21), .oRD_ADDR_2(r22), .oROM_ADDR(rom2),
    .oWR_EN(we2), .oWR_BANK(wb2), .oWR_ADDR_0(w20), .oWR_ADDR_1(w21));

  // Hand-derived N=8 tables, [stage][j]
  int TA [0:2][0:3] = '{'{0,2,4,6}, '{0,1,4,5}, '{0,1,2,3}};
  int TB [0:2][0:3] = '{'{1,3,5,7}, '{2,3,6,7}, '{4,5,6,7}};
  int TC [0:2][0:3] = '{'{1,3,5,7}, '{2,3,6,7}, '{4,7,6,5}};
  int TR [0:2][0:3] = '{'{0,0,0,0}, '{0,2,0,2}, '{0,1,2,3}};

  int n_assert = 0;
  int n_fail   = 0;

  logic       hist_v [0:63];
  logic [3:0] hist_a [0:63];
  logic [3:0] hist_b [0:63];
  int         done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {7'd0, busy, done, stage, rd_en, rd_bank, ra0, ra1, ra2, rom,
              wr_en, wr_bank, wa0, wa1}, 32'd0);
  endtask

  // One N=8 transform; caller is in cycle 0. Checks cycles 1..20 unless a
  // reset is injected during cycle rst_cyc, in which case it stops at rst_cyc+1.
  task automatic run(input string nm, input bit extra, input bit start_at_done, input int rst_cyc);
    int st, pos, w, ws, wp;
    bit wexp;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start = (extra && (cyc == 2 || cyc == 10)) || (start_at_done && cyc == 19);
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        chk_zero($sformatf("%s post-reset outputs", nm));
        rst = 1'b0;
        return;
      end
      if (cyc <= 18) begin
        st  = (cyc - 1) / 6;
        pos = (cyc - 1) % 6;
        chk($sformatf("%s busy c%0d", nm, cyc), busy, 1);
        chk($sformatf("%s done c%0d", nm, cyc), done, 0);
        chk($sformatf("%s stage c%0d", nm, cyc), stage, st);
        chk($sformatf("%s rd_en c%0d", nm, cyc), rd_en, (pos < 4) ? 1 : 0);
        if (pos < 4) begin
          chk($sformatf("%s rd_a c%0d", nm, cyc), ra0, TA[st][pos]);
          chk($sformatf("%s rd_b c%0d", nm, cyc), ra1, TB[st][pos]);
          chk($sformatf("%s rd_c c%0d", nm, cyc), ra2, TC[st][pos]);
          chk($sformatf("%s rom c%0d", nm, cyc), rom, TR[st][pos]);
          chk($sformatf("%s rd_bank c%0d", nm, cyc), rd_bank, st % 2);
        end
      end else begin
        chk($sformatf("%s busy c%0d", nm, cyc), busy, 0);
        chk($sformatf("%s done c%0d", nm, cyc), done, (cyc == 19) ? 1 : 0);
        chk($sformatf("%s rd_en c%0d", nm, cyc), rd_en, 0);
      end
      w    = cyc - 2;
      wexp = (w >= 1) && (((w - 1) % 6) < 4);
      chk($sformatf("%s wr_en c%0d", nm, cyc), wr_en, wexp);
      if (wexp) begin
        ws = (w - 1) / 6;
        wp = (w - 1) % 6;
        chk($sformatf("%s wr_a c%0d", nm, cyc), wa0, TA[ws][wp]);
        chk($sformatf("%s wr_b c%0d", nm, cyc), wa1, TB[ws][wp]);
        chk($sformatf("%s wr_bank c%0d", nm, cyc), wr_bank, 1 - (ws % 2));
      end
      if (cyc == rst_cyc) rst = 1'b1;
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) step();
    chk_zero("reset state");
    chk("reset busy2", {b2, re2, we2, d2}, 4'd0);
    rst = 1'b0;
    step();
    chk_zero("idle state");

    run("r1", 1'b0, 1'b1, 0);   // start during oDONE cycle must be ignored
    run("r2", 1'b1, 1'b0, 0);   // accepted one cycle after oDONE; extra starts ignored
    run("r3", 1'b0, 1'b0, 9);   // reset during cycle 9

    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("after reset wr_en %0d", i), wr_en, 0);
      chk($sformatf("after reset busy %0d", i), {busy, rd_en}, 2'b00);
    end
    run("r4", 1'b0, 1'b0, 0);   // restart from stage 0, j 0

    // Latency sweep: N=16, D=4
    done_at = 0;
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      step();
      start2 = 1'b0;
      hist_v[cyc] = re2;
      hist_a[cyc] = r20;
      hist_b[cyc] = r21;
      if (d2 && done_at == 0) done_at = cyc;
      if (cyc <= 4) chk($sformatf("sweep wr_en c%0d", cyc), we2, 0);
      else begin
        chk($sformatf("sweep wr_en c%0d", cyc), we2, hist_v[cyc-4]);
        if (hist_v[cyc-4]) begin
          chk($sformatf("sweep wr_a c%0d", cyc), w20, hist_a[cyc-4]);
          chk($sformatf("sweep wr_b c%0d", cyc), w21, hist_b[cyc-4]);
        end
      end
      if (cyc == 30) chk("sweep s2 j5", {re2, r20, r21, r22, rom2}, {1'b1, 4'd9, 4'd13, 4'd15, 3'd2});
      if (cyc == 42) chk("sweep s3 j5", {re2, r20, r21, r22, rom2}, {1'b1, 4'd5, 4'd13, 4'd11, 3'd5});
      if (cyc == 48) chk("sweep busy c48", b2, 1);
    end
    chk("sweep done cycle", done_at, 49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
